vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fb_arbiter_if.sv | 33 +++
 rtl/vga_pix_fifo.sv | 57 +++++
 rtl/vga_fb_arbiter.sv | 121 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel format, 800x600 timing constants, fetch FSM states.
package vga_pkg;

  localparam int unsigned RGB_W = 12;

  localparam int unsigned H_VISIBLE     = 800;
  localparam int unsigned H_FRONT_PORCH = 56;
  localparam int unsigned H_SYNC_PULSE  = 120;
  localparam int unsigned H_BACK_PORCH  = 64;
  localparam int unsigned H_TOTAL       = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

  localparam int unsigned V_VISIBLE     = 600;
  localparam int unsigned V_FRONT_PORCH = 37;
  localparam int unsigned V_SYNC_PULSE  = 6;
  localparam int unsigned V_BACK_PORCH  = 23;
  localparam int unsigned V_TOTAL       = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  // {R[3:0], G[3:0], B[3:0]}
  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display, writer and framebuffer-memory signals of the arbiter.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 19
) ();

  logic               frame_start;
  logic               pix_rd;
  vga_pkg::rgb_t      pix_data;
  logic               pix_valid;
  logic               underflow;
  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  vga_pkg::rgb_t      wr_data;
  logic               mem_re;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  vga_pkg::rgb_t      mem_wdata;
  vga_pkg::rgb_t      mem_rdata;

  // Arbiter side
  modport slave (
    input  frame_start, pix_rd, wr_valid, wr_addr, wr_data, mem_rdata,
    output pix_data, pix_valid, underflow, wr_ready, mem_re, mem_we, mem_addr, mem_wdata
  );

  // Display / writer / memory side
  modport master (
    output frame_start, pix_rd, wr_valid, wr_addr, wr_data, mem_rdata,
    input  pix_data, pix_valid, underflow, wr_ready, mem_re, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel prefetch FIFO with flush and occupancy count.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  rgb_t                   wdata_i,
  input  logic                   pop_i,
  output rgb_t                   rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  rgb_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          full, do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one memory port between linear display prefetch and a pixel writer.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = H_VISIBLE,
  parameter int unsigned V_VISIBLE_AREA = V_VISIBLE,
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic            VGA_CLK,
  input  logic            RESET,
  vga_fb_arbiter_if.slave bus
);

  localparam int unsigned        CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   HALF_C    = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_VISIBLE_AREA * V_VISIBLE_AREA - 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_addr_q, mem_addr_q;
  rgb_t              mem_wdata_q;
  logic              mem_re_q, mem_we_q;
  logic              rd_pend_q;     // read whose data is on mem_rdata this cycle
  logic              prio_wr_q;     // contended-grant priority: 0 = read, 1 = write
  logic              underflow_q;

  logic [CNT_W-1:0]  occ, inflight;
  logic              fifo_empty, fifo_push, fifo_pop;
  rgb_t              fifo_head;
  logic              rd_req, rd_gnt, wr_gnt, contended;

  // A frame_start flush also kills the read whose data is arriving right now.
  assign fifo_push = rd_pend_q && !bus.frame_start;
  assign fifo_pop  = bus.pix_rd && !fifo_empty;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (VGA_CLK),
    .rst_i   (RESET),
    .flush_i (bus.frame_start),
    .push_i  (fifo_push),
    .wdata_i (bus.mem_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (occ),
    .empty_o (fifo_empty)
  );

  // Request generation and one-grant-per-cycle arbitration.
  always_comb begin
    inflight  = CNT_W'(mem_re_q) + CNT_W'(rd_pend_q);
    rd_req    = (state_q == ST_FETCH) && !bus.frame_start && ((occ + inflight) < DEPTH_C);
    contended = rd_req && bus.wr_valid && (occ >= HALF_C);
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    if (!RESET) begin
      if (rd_req && bus.wr_valid) begin
        if ((occ < HALF_C) || !prio_wr_q) rd_gnt = 1'b1;
        else                              wr_gnt = 1'b1;
      end else begin
        rd_gnt = rd_req;
        wr_gnt = bus.wr_valid;
      end
    end
  end

  // Fetch FSM, registered memory strobes, read pipeline, priority and underflow tracking.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      prio_wr_q    <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mem_re_q  <= rd_gnt;
      mem_we_q  <= wr_gnt;
      rd_pend_q <= mem_re_q && !bus.frame_start;
      if (rd_gnt) begin
        mem_addr_q <= fetch_addr_q;
      end else if (wr_gnt) begin
        mem_addr_q  <= bus.wr_addr;
        mem_wdata_q <= bus.wr_data;
      end
      if (contended) prio_wr_q <= !prio_wr_q;
      if (bus.pix_rd && fifo_empty) underflow_q <= 1'b1;

      if (bus.frame_start) begin
        state_q      <= ST_FETCH;
        fetch_addr_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE:  fetch_addr_q <= '0;
          ST_FETCH: begin
            if (rd_gnt) begin
              fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
              if (fetch_addr_q == LAST_ADDR) state_q <= ST_DONE;
            end
          end
          ST_DONE:  state_q <= ST_DONE;
        endcase
      end
    end
  end

  assign bus.wr_ready  = wr_gnt;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.pix_data  = fifo_head;
  assign bus.pix_valid = !fifo_empty;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x8 frame.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 8;
  localparam int unsigned AW    = 19;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NPIX  = H * V;
  localparam logic [AW-1:0] WADDR = 19'h00123;
  localparam logic [11:0]   WDATA = 12'hBEE;

  typedef struct {
    logic          fs;
    logic          rd;
    logic          wv;
    logic          exp_rdy;
    logic          exp_re;
    logic          exp_we;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [26];

  vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

  vga_fb_arbiter #(
    .H_VISIBLE_AREA (H),
    .V_VISIBLE_AREA (V),
    .ADDR_W         (AW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .VGA_CLK (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix_of(input logic [AW-1:0] a);
    return a[11:0] ^ 12'hA5C;
  endfunction

  // Memory model: read data is a fixed function of the address, one cycle late.
  always @(posedge clk) bus.mem_rdata <= pix_of(bus.mem_addr);

  always @(negedge clk) begin
    checks++;
    if (bus.mem_re && bus.mem_we) begin
      errors++;
      $display("FAIL re_we_exclusive: got mem_re=1 mem_we=1 expected at most one at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic fs, input logic rd, input logic wv);
    bus.frame_start = fs;
    bus.pix_rd      = rd;
    bus.wr_valid    = wv;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic fill();
    set_in(1'b1, 1'b0, 1'b0);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    repeat (25) adv();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_re"},    32'(bus.mem_re),    32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    chk({tag, "_pix_data"},  32'(bus.pix_data),  32'd0);
    chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
  endtask

  // Hand-derived grant schedule for continuous wr_valid after frame_start, no pops:
  // -1 = write grant, otherwise the read address granted in cycle j after frame_start.
  function automatic int gk(input int j);
    if (j < 0)        return -1;
    if (j <= 10)      return j;
    if (j >= 21)      return -1;
    if (j % 2 == 1)   return -1;
    return 11 + (j - 12) / 2;
  endfunction

  initial begin
    int unsigned nrd;
    int unsigned n;
    logic [AW-1:0] last;
    logic found;

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b1);
    bus.wr_addr = WADDR;
    bus.wr_data = WDATA;

    // Outputs while reset is held, with a pending writer
    adv();
    adv();
    @(negedge clk);
    chk_reset_outputs("reset");
    adv();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);

    // Contention table: continuous wr_valid from frame_start, display idle
    tbl[0].fs = 1'b1; tbl[0].rd = 1'b0; tbl[0].wv = 1'b1;
    tbl[0].exp_rdy = 1'b1; tbl[0].exp_re = 1'b0; tbl[0].exp_we = 1'b0;
    tbl[0].exp_valid = 1'b0; tbl[0].exp_addr = '0;
    for (int unsigned i = 1; i < 26; i++) begin
      int j, cur, prev;
      j    = int'(i) - 1;
      cur  = gk(j);
      prev = gk(j - 1);
      tbl[i].fs        = 1'b0;
      tbl[i].rd        = 1'b0;
      tbl[i].wv        = 1'b1;
      tbl[i].exp_rdy   = (cur < 0);
      tbl[i].exp_re    = (prev >= 0);
      tbl[i].exp_we    = (prev < 0);
      tbl[i].exp_valid = (j >= 3);
      tbl[i].exp_addr  = (prev >= 0) ? AW'(prev) : WADDR;
    end
    for (int unsigned i = 0; i < 26; i++) begin
      set_in(tbl[i].fs, tbl[i].rd, tbl[i].wv);
      @(negedge clk);
      chk($sformatf("tbl%0d_wr_ready", i),  32'(bus.wr_ready),  32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_mem_re", i),    32'(bus.mem_re),    32'(tbl[i].exp_re));
      chk($sformatf("tbl%0d_mem_we", i),    32'(bus.mem_we),    32'(tbl[i].exp_we));
      chk($sformatf("tbl%0d_pix_valid", i), 32'(bus.pix_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_re || tbl[i].exp_we)
        chk($sformatf("tbl%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].exp_addr));
      if (tbl[i].exp_we)
        chk($sformatf("tbl%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(WDATA));
      adv();
    end

    // Prefetch fills to exactly FIFO_DEPTH reads at addresses 0..15, then stops
    do_reset();
    set_in(1'b1, 1'b0, 1'b0);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    nrd = 0;
    for (int unsigned c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.mem_re) begin
        chk("fill_addr", 32'(bus.mem_addr), nrd);
        nrd++;
      end
      adv();
    end
    chk("fill_count", nrd, 32'(DEPTH));
    @(negedge clk);
    chk("fill_valid", 32'(bus.pix_valid), 32'd1);
    chk("fill_head",  32'(bus.pix_data),  32'(pix_of('0)));
    chk("fill_re_idle", 32'(bus.mem_re),  32'd0);
    adv();

    // Popping before any data arrives sets a sticky underflow
    do_reset();
    set_in(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("uf_initial", 32'(bus.underflow), 32'd0);
    adv();
    set_in(1'b0, 1'b1, 1'b0);
    for (int unsigned c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("uf_sticky", 32'(bus.underflow), 32'd1);
      adv();
    end
    set_in(1'b1, 1'b0, 1'b0);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("uf_after_frame_start", 32'(bus.underflow), 32'd1);
    adv();
    do_reset();
    @(negedge clk);
    chk("uf_cleared_by_reset", 32'(bus.underflow), 32'd0);
    adv();

    // frame_start with two reads in flight: flush, discard, restart at 0
    do_reset();
    fill();
    set_in(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    n = 0;
    for (int unsigned c = 0; c < 120 && !found; c++) begin
      @(negedge clk);
      if (bus.pix_valid) begin
        chk("flush_pre_data", 32'(bus.pix_data), 32'(pix_of(AW'(n))));
        n++;
      end
      if (bus.mem_re && bus.mem_addr == AW'(39)) found = 1'b1;
      adv();
    end
    chk("flush_trigger_seen", 32'(found), 32'd1);
    set_in(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_inflight_re",   32'(bus.mem_re),   32'd1);
    chk("flush_inflight_addr", 32'(bus.mem_addr), 32'd40);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_empty_1",   32'(bus.pix_valid), 32'd0);
    chk("flush_read_blocked", 32'(bus.mem_re), 32'd0);
    adv();
    @(negedge clk);
    chk("flush_empty_2",   32'(bus.pix_valid), 32'd0);
    chk("flush_restart_re",   32'(bus.mem_re),   32'd1);
    chk("flush_restart_addr", 32'(bus.mem_addr), 32'd0);
    adv();
    @(negedge clk);
    chk("flush_empty_3", 32'(bus.pix_valid), 32'd0);
    adv();
    @(negedge clk);
    chk("flush_first_valid", 32'(bus.pix_valid), 32'd1);
    chk("flush_first_data",  32'(bus.pix_data),  32'(pix_of('0)));
    adv();

    // Whole frame popped one per cycle: ends in DONE after the last address
    do_reset();
    fill();
    set_in(1'b0, 1'b1, 1'b0);
    n = 0;
    last = '0;
    for (int unsigned c = 0; c < 400 && n < NPIX; c++) begin
      @(negedge clk);
      if (bus.mem_re) last = bus.mem_addr;
      if (bus.pix_valid) begin
        chk("frame_data", 32'(bus.pix_data), 32'(pix_of(AW'(n))));
        n++;
      end
      adv();
    end
    set_in(1'b0, 1'b0, 1'b0);
    chk("frame_pop_count", n, NPIX);
    chk("frame_last_addr", 32'(last), NPIX - 1);
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("done_no_read", 32'(bus.mem_re),    32'd0);
      chk("done_empty",   32'(bus.pix_valid), 32'd0);
      adv();
    end
    set_in(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_wr_ready_1", 32'(bus.wr_ready), 32'd1);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_wr_ready_0", 32'(bus.wr_ready), 32'd0);
    chk("done_mem_we",     32'(bus.mem_we),   32'd1);
    adv();

    // Reset in the middle of a fetch with a write being granted
    do_reset();
    fill();
    set_in(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("midreset_wr_granted", 32'(bus.wr_ready), 32'd1);
    adv();
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_we_out",   32'(bus.mem_we),   32'd1);
    chk("midreset_ready_gated", 32'(bus.wr_ready), 32'd0);
    adv();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_reset_outputs("midreset");
    adv();
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midreset_idle_no_read", 32'(bus.mem_re), 32'd0);
      adv();
    end
    set_in(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("midreset_idle_wr_ready", 32'(bus.wr_ready), 32'd1);
    adv();
    set_in(1'b0, 1'b0, 1'b0);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
